// File: rtl/fp_cmp_serial.sv
// fp_cmp_serial -- multi-cycle floating-point comparator.
//
// Compares two {sign, exp, man} operands. The unsigned {exp, man} magnitude
// fields are subtracted serially, LSB chunk first, CHUNK_W bits per cycle.
// The final borrow and an all-zero tracker give the magnitude ordering. That
// ordering is then combined with the signs, the NaN detection and the
// requested mode to form a single result flag.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_valid     request strobe; accepted when in_ready is high
//   in_ready     high only while idle
//   a, b         operands {sign, exp[EXP_W], man[MAN_W]}
//   signed_mode  1: full signed ordering, 0: magnitude-only
//   done         one-cycle pulse; result flags are valid from this cycle on
//   a_big        A > B
//   b_big        B > A
//   equal        A == B
//   unordered    either operand is NaN
module fp_cmp_serial #(
  parameter int EXP_W   = 5,
  parameter int MAN_W   = 10,
  parameter int CHUNK_W = 4,
  localparam int W      = 1 + EXP_W + MAN_W,
  localparam int MAGW   = EXP_W + MAN_W,
  localparam int NCHUNK = (MAGW + CHUNK_W - 1) / CHUNK_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         signed_mode,
  output logic         done,
  output logic         a_big,
  output logic         b_big,
  output logic         equal,
  output logic         unordered
);

  localparam int PADW = NCHUNK * CHUNK_W;
  localparam int CNTW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NCHUNK - 1);

  // Result flag encoding: {a_big, b_big, equal, unordered}
  localparam logic [3:0] R_AB = 4'b1000;
  localparam logic [3:0] R_BB = 4'b0100;
  localparam logic [3:0] R_EQ = 4'b0010;
  localparam logic [3:0] R_UN = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Control state (reset)
  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            borrow_q, borrow_d;
  logic            zero_q, zero_d;
  logic [3:0]      flags_q, flags_d;

  // Latched operand data (no reset)
  logic [PADW-1:0] ma_q, ma_d;
  logic [PADW-1:0] mb_q, mb_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            smode_q, smode_d;
  logic            nan_a_q, nan_a_d;
  logic            nan_b_q, nan_b_d;
  logic            za_q, za_d;
  logic            zb_q, zb_d;

  // Combine magnitude ordering, signs, NaN and mode into one result flag.
  // Two negative operands invert the magnitude ordering; +0 and -0 are equal.
  function automatic logic [3:0] resolve(
    input logic mag_eq,
    input logic mag_lt,
    input logic smode,
    input logic sign_a,
    input logic sign_b,
    input logic nan_any,
    input logic both_zero
  );
    logic [3:0] r;
    r = R_EQ;
    if (nan_any)
      r = R_UN;
    else if (!smode || (!sign_a && !sign_b))
      r = mag_eq ? R_EQ : (mag_lt ? R_BB : R_AB);
    else if (both_zero)
      r = R_EQ;
    else if (sign_a != sign_b)
      r = sign_a ? R_BB : R_AB;
    else
      r = mag_eq ? R_EQ : (mag_lt ? R_AB : R_BB);
    return r;
  endfunction

  // Operand field decode at accept time; magnitudes are zero-padded to a
  // whole number of chunks so the top chunk needs no special case.
  logic [PADW-1:0] a_pad, b_pad;
  logic            a_nan, b_nan;

  always_comb begin
    a_pad = '0;
    b_pad = '0;
    a_pad[MAGW-1:0] = a[MAGW-1:0];
    b_pad[MAGW-1:0] = b[MAGW-1:0];
    a_nan = (&a[W-2 -: EXP_W]) && (|a[MAN_W-1:0]);
    b_nan = (&b[W-2 -: EXP_W]) && (|b[MAN_W-1:0]);
  end

  // Serial subtract of the current (lowest) chunk. The magnitude registers
  // shift right each RUN cycle, so the active chunk is always at bit 0.
  logic [CHUNK_W:0] diff;
  logic             fin_zero;

  always_comb begin
    diff     = {1'b0, ma_q[CHUNK_W-1:0]} - {1'b0, mb_q[CHUNK_W-1:0]}
               - (CHUNK_W+1)'(borrow_q);
    fin_zero = zero_q && (diff[CHUNK_W-1:0] == '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    flags_d  = flags_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    smode_d  = smode_q;
    nan_a_d  = nan_a_q;
    nan_b_d  = nan_b_q;
    za_d     = za_q;
    zb_d     = zb_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d  = S_RUN;
          ma_d     = a_pad;
          mb_d     = b_pad;
          sa_d     = a[W-1];
          sb_d     = b[W-1];
          smode_d  = signed_mode;
          nan_a_d  = a_nan;
          nan_b_d  = b_nan;
          za_d     = (a[MAGW-1:0] == '0);
          zb_d     = (b[MAGW-1:0] == '0);
          borrow_d = 1'b0;
          zero_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        ma_d     = ma_q >> CHUNK_W;
        mb_d     = mb_q >> CHUNK_W;
        borrow_d = diff[CHUNK_W];
        zero_d   = fin_zero;
        if (cnt_q == LAST_CNT) begin
          // Counter holds at its last value; it is cleared on the next accept.
          state_d = S_DONE;
          flags_d = resolve(fin_zero, diff[CHUNK_W], smode_q, sa_q, sb_q,
                            nan_a_q || nan_b_q, za_q && zb_q);
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    ma_q    <= ma_d;
    mb_q    <= mb_d;
    sa_q    <= sa_d;
    sb_q    <= sb_d;
    smode_q <= smode_d;
    nan_a_q <= nan_a_d;
    nan_b_q <= nan_b_d;
    za_q    <= za_d;
    zb_q    <= zb_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign a_big     = flags_q[3];
  assign b_big     = flags_q[2];
  assign equal     = flags_q[1];
  assign unordered = flags_q[0];

endmodule

// File: tb/tb_fp_cmp_serial.sv
module tb_fp_cmp_serial;

  localparam logic [3:0] AB = 4'b1000;
  localparam logic [3:0] BB = 4'b0100;
  localparam logic [3:0] EQ = 4'b0010;
  localparam logic [3:0] UN = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   vecs = 0;
  int   errs = 0;

  // Default configuration (half precision, CHUNK_W=4, NCHUNK=4)
  logic        in_valid, sm;
  logic [15:0] a, b;
  logic        in_ready, done, a_big, b_big, equal, unordered;

  fp_cmp_serial u16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(sm), .done(done), .a_big(a_big),
    .b_big(b_big), .equal(equal), .unordered(unordered)
  );

  // Single-precision configurations: index 0 CHUNK_W=1, 1 CHUNK_W=7, 2 CHUNK_W=31
  logic [2:0]  v32, sm32, rdy32, dn32, ab32, bb32, eq32, un32;
  logic [31:0] a32 [3];
  logic [31:0] b32 [3];

  fp_cmp_serial #(.EXP_W(8), .MAN_W(23), .CHUNK_W(1)) u32_c1 (
    .clk(clk), .reset(reset), .in_valid(v32[0]), .in_ready(rdy32[0]),
    .a(a32[0]), .b(b32[0]), .signed_mode(sm32[0]), .done(dn32[0]),
    .a_big(ab32[0]), .b_big(bb32[0]), .equal(eq32[0]), .unordered(un32[0])
  );
  fp_cmp_serial #(.EXP_W(8), .MAN_W(23), .CHUNK_W(7)) u32_c7 (
    .clk(clk), .reset(reset), .in_valid(v32[1]), .in_ready(rdy32[1]),
    .a(a32[1]), .b(b32[1]), .signed_mode(sm32[1]), .done(dn32[1]),
    .a_big(ab32[1]), .b_big(bb32[1]), .equal(eq32[1]), .unordered(un32[1])
  );
  fp_cmp_serial #(.EXP_W(8), .MAN_W(23), .CHUNK_W(31)) u32_c31 (
    .clk(clk), .reset(reset), .in_valid(v32[2]), .in_ready(rdy32[2]),
    .a(a32[2]), .b(b32[2]), .signed_mode(sm32[2]), .done(dn32[2]),
    .a_big(ab32[2]), .b_big(bb32[2]), .equal(eq32[2]), .unordered(un32[2])
  );

  // Reference ordering for single precision, written directly from the
  // IEEE-style field definitions using whole-word magnitude comparison.
  function automatic logic [3:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                       input logic s);
    logic [30:0] mx, my;
    logic        nx, ny;
    mx = x[30:0];
    my = y[30:0];
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    if (nx || ny) return UN;
    if (!s) return (mx > my) ? AB : ((mx < my) ? BB : EQ);
    if (mx == 31'd0 && my == 31'd0) return EQ;
    if (x[31] != y[31]) return x[31] ? BB : AB;
    if (!x[31]) return (mx > my) ? AB : ((mx < my) ? BB : EQ);
    return (mx > my) ? BB : ((mx < my) ? AB : EQ);
  endfunction

  // One request on the default DUT. lat counts edges from the accepting edge
  // (as edge 1) to the edge after which done is seen; busy counts cycles with
  // in_ready low. The operand inputs are scrambled after accept.
  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic smv,
                       output logic [3:0] fl, output int lat, output int busy,
                       output logic pdone, output logic prdy);
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; sm = smv;
    @(posedge clk);
    lat = 1; busy = 0;
    @(negedge clk);
    in_valid = 1'b0; a = 16'hFFFF; b = 16'h0000; sm = ~smv;
    while (!done && lat < 40) begin
      if (!in_ready) busy++;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (done && !in_ready) busy++;
    fl = {a_big, b_big, equal, unordered};
    @(posedge clk);
    @(negedge clk);
    pdone = done;
    prdy  = in_ready;
  endtask

  task automatic run32(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic smv, output logic [3:0] fl, output int lat);
    @(negedge clk);
    v32[k] = 1'b1; a32[k] = av; b32[k] = bv; sm32[k] = smv;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    v32[k] = 1'b0; a32[k] = ~av; b32[k] = ~bv; sm32[k] = ~smv;
    while (!dn32[k] && lat < 80) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    fl = {ab32[k], bb32[k], eq32[k], un32[k]};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL reset_ctl: ready=%b done=%b want ready=1 done=0", in_ready, done);
    end
    vecs++;
    if ({a_big, b_big, equal, unordered} !== 4'b0000) begin
      errs++; $display("FAIL reset_flags: got %b want 0000", {a_big, b_big, equal, unordered});
    end
    vecs++;
    if (rdy32 !== 3'b111 || dn32 !== 3'b000 || (ab32 | bb32 | eq32 | un32) !== 3'b000) begin
      errs++; $display("FAIL reset_32: rdy=%b done=%b flags_or=%b want 111/000/000",
                       rdy32, dn32, ab32 | bb32 | eq32 | un32);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({done, a_big, b_big, equal, unordered} !== 5'b00000 || in_ready !== 1'b1) begin
      errs++; $display("FAIL idle_after_reset: done/flags=%b ready=%b want 00000/1",
                       {done, a_big, b_big, equal, unordered}, in_ready);
    end
  endtask

  task automatic test_magnitude();
    logic [3:0] fl; int lat, busy; logic pd, pr;
    run16(16'h3C00, 16'h4000, 1'b0, fl, lat, busy, pd, pr);
    vecs++;
    if (fl !== BB) begin errs++; $display("FAIL mag_1v2: got %b want %b", fl, BB); end
    vecs++;
    if (lat !== 5) begin errs++; $display("FAIL mag_latency: got %0d want 5", lat); end
    vecs++;
    if (busy !== 5) begin errs++; $display("FAIL mag_ready_low: got %0d want 5", busy); end
    vecs++;
    if (pd !== 1'b0) begin errs++; $display("FAIL mag_done_pulse: got %b want 0", pd); end
    vecs++;
    if (pr !== 1'b1) begin errs++; $display("FAIL mag_ready_return: got %b want 1", pr); end
  endtask

  // Directed vector table: {a, b, signed_mode, expected flags}
  task automatic run_table(input string name, input logic [15:0] ta [], input logic [15:0] tb [],
                           input logic ts [], input logic [3:0] te []);
    logic [3:0] fl; int lat, busy; logic pd, pr;
    for (int i = 0; i < ta.size(); i++) begin
      run16(ta[i], tb[i], ts[i], fl, lat, busy, pd, pr);
      vecs++;
      if (fl !== te[i] || lat !== 5) begin
        errs++;
        $display("FAIL %s[%0d] a=%h b=%h sm=%b: flags=%b lat=%0d want flags=%b lat=5",
                 name, i, ta[i], tb[i], ts[i], fl, lat, te[i]);
      end
    end
  endtask

  task automatic test_signed();
    run_table("signed", '{16'hC000, 16'hC000, 16'hC000, 16'h3C00},
                        '{16'h3C00, 16'h3C00, 16'hBC00, 16'hBC00},
                        '{1'b1, 1'b0, 1'b1, 1'b1},
                        '{BB, AB, BB, AB});
  endtask

  task automatic test_zero_equal();
    run_table("zero_eq", '{16'h0000, 16'h3555, 16'h3556, 16'h0000, 16'h3555},
                         '{16'h8000, 16'h3555, 16'h3555, 16'h8000, 16'h3556},
                         '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
                         '{EQ, EQ, AB, EQ, BB});
  endtask

  task automatic test_nan_inf();
    run_table("nan_inf", '{16'h7E00, 16'h7C00, 16'h3C00, 16'hFC00, 16'h7C00},
                         '{16'h3C00, 16'h7BFF, 16'hFC01, 16'h7C00, 16'h7C00},
                         '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1},
                         '{UN, AB, UN, BB, EQ});
  endtask

  task automatic test_reset_midop();
    logic [3:0] fl; int lat, busy; logic pd, pr; int ndone;
    @(negedge clk);
    in_valid = 1'b1; a = 16'h4000; b = 16'h3C00; sm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    vecs++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL midreset_ctl: ready=%b done=%b want 1/0", in_ready, done);
    end
    vecs++;
    if ({a_big, b_big, equal, unordered} !== 4'b0000) begin
      errs++; $display("FAIL midreset_flags: got %b want 0000", {a_big, b_big, equal, unordered});
    end
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    vecs++;
    if (ndone !== 0) begin errs++; $display("FAIL midreset_no_done: got %0d pulses want 0", ndone); end
    run16(16'h3C00, 16'h4000, 1'b0, fl, lat, busy, pd, pr);
    vecs++;
    if (fl !== BB || lat !== 5) begin
      errs++; $display("FAIL midreset_recover: flags=%b lat=%0d want %b lat=5", fl, lat, BB);
    end
  endtask

  // in_valid held high: the done cycle must not accept, so completions are
  // spaced NCHUNK+2 cycles apart.
  task automatic test_back_to_back();
    int edges; int d [3]; int nd;
    edges = 0; nd = 0;
    @(negedge clk);
    in_valid = 1'b1; a = 16'h4000; b = 16'h3C00; sm = 1'b0;
    while (nd < 3 && edges < 60) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (done) begin
        d[nd] = edges;
        if (nd == 0) begin
          vecs++;
          if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready_in_done: got %b want 0", in_ready); end
        end
        vecs++;
        if ({a_big, b_big, equal, unordered} !== AB) begin
          errs++; $display("FAIL b2b_flags[%0d]: got %b want %b", nd, {a_big, b_big, equal, unordered}, AB);
        end
        nd++;
      end
    end
    in_valid = 1'b0;
    vecs++;
    if (nd !== 3) begin
      errs++; $display("FAIL b2b_count: got %0d dones want 3", nd);
    end else if (d[0] !== 5 || d[1] - d[0] !== 6 || d[2] - d[1] !== 6) begin
      errs++; $display("FAIL b2b_spacing: first=%0d gaps=%0d,%0d want 5,6,6", d[0], d[1] - d[0], d[2] - d[1]);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_sweep32(input int k, input int nch);
    logic [31:0] av, bv; logic smv; logic [3:0] fl, ex; int lat;
    for (int i = 0; i < 1000; i++) begin
      av = $urandom; bv = $urandom;
      case (i % 8)
        0: bv = av;
        1: bv = av ^ 32'h8000_0000;
        2: begin av[30:23] = 8'hFF; if (i % 16 == 2) av[22:0] = 23'd0; end
        3: begin av = av & 32'h8000_0000; bv = bv & 32'h8000_0000; end
        4: bv = av ^ ($urandom & 32'h0000_00FF);
        5: begin bv = av; bv[30:23] = 8'hFF; bv[22:0] = 23'd0; end
        default: ;
      endcase
      smv = 1'($urandom_range(0, 1));
      ex = ref32(av, bv, smv);
      run32(k, av, bv, smv, fl, lat);
      vecs++;
      if (fl !== ex || lat !== nch + 1) begin
        errs++;
        $display("FAIL sweep%0d[%0d] a=%h b=%h sm=%b: flags=%b lat=%0d want flags=%b lat=%0d",
                 k, i, av, bv, smv, fl, lat, ex, nch + 1);
      end
    end
  endtask

  task automatic test_back_to_back32(input int k, input int nch);
    int edges; int d [3]; int nd;
    edges = 0; nd = 0;
    @(negedge clk);
    v32[k] = 1'b1; a32[k] = 32'h3F80_0000; b32[k] = 32'h4000_0000; sm32[k] = 1'b0;
    while (nd < 3 && edges < 200) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (dn32[k]) begin
        d[nd] = edges;
        vecs++;
        if ({ab32[k], bb32[k], eq32[k], un32[k]} !== BB) begin
          errs++; $display("FAIL b2b32_%0d_flags[%0d]: got %b want %b", k, nd,
                           {ab32[k], bb32[k], eq32[k], un32[k]}, BB);
        end
        nd++;
      end
    end
    v32[k] = 1'b0;
    vecs++;
    if (nd !== 3) begin
      errs++; $display("FAIL b2b32_%0d_count: got %0d want 3", k, nd);
    end else if (d[0] !== nch + 1 || d[1] - d[0] !== nch + 2 || d[2] - d[1] !== nch + 2) begin
      errs++; $display("FAIL b2b32_%0d_spacing: first=%0d gaps=%0d,%0d want %0d,%0d,%0d",
                       k, d[0], d[1] - d[0], d[2] - d[1], nch + 1, nch + 2, nch + 2);
    end
    repeat (nch + 4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sm = 1'b0;
    v32 = '0; sm32 = '0;
    for (int i = 0; i < 3; i++) begin a32[i] = '0; b32[i] = '0; end

    test_reset();
    test_magnitude();
    test_signed();
    test_zero_equal();
    test_nan_inf();
    test_reset_midop();
    test_back_to_back();
    test_sweep32(0, 31);
    test_back_to_back32(0, 31);
    test_sweep32(1, 5);
    test_back_to_back32(1, 5);
    test_sweep32(2, 1);
    test_back_to_back32(2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
